// File: rtl/dice_roll_controller_pkg.sv
// dice_pkg: FSM states, blank code, die table and small helpers shared by
// the dice roll controller files.
package dice_pkg;

    typedef enum logic [2:0] {IDLE, PRESS_DB, ROLL, RELEASE_DB, SHOW} state_t;

    localparam logic [3:0] BLANK = 4'hF;
    localparam int DIE_N [7] = '{4, 6, 8, 10, 12, 20, 100};

    function automatic logic [6:0] die_max(input logic [2:0] idx);
        return 7'(DIE_N[idx] - 1);
    endfunction

    // Lowest-index set bit wins when several buttons are pressed together.
    function automatic logic [2:0] lowest_set(input logic [6:0] v);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 6; i >= 0; i--) if (v[i]) r = 3'(i);
        return r;
    endfunction

endpackage

// File: rtl/dice_roll_controller_if.sv
// dice_roll_controller_if: button inputs and display/result outputs of the
// dice roll controller; master drives buttons, slave is the controller.
interface dice_roll_controller_if;
    logic       ena;
    logic       btn_active_high;
    logic [6:0] btn_raw;
    logic [3:0] digit1;
    logic [3:0] digit10;
    logic [6:0] result;
    logic       result_valid;
    logic [2:0] die_sel;
    logic       rolling;

    modport master (
        output ena, btn_active_high, btn_raw,
        input  digit1, digit10, result, result_valid, die_sel, rolling
    );

    modport slave (
        input  ena, btn_active_high, btn_raw,
        output digit1, digit10, result, result_valid, die_sel, rolling
    );
endinterface

// File: rtl/dice_roll_controller_bin_to_bcd.sv
// dice_bin_to_bcd: 1..100 to {tens, ones} BCD; tens blanked below 10 and
// 100 displayed as 00 on the two-digit display.
module dice_bin_to_bcd
    import dice_pkg::*;
(
    input  logic [6:0] val_i,
    output logic [3:0] tens_o,
    output logic [3:0] ones_o
);
    assign tens_o = val_i >= 7'd100 ? 4'd0 : val_i < 7'd10 ? BLANK : 4'(val_i / 7'd10);
    assign ones_o = val_i >= 7'd100 ? 4'd0 : 4'(val_i % 7'd10);
endmodule

// File: rtl/dice_roll_controller.sv
// dice_roll_controller: arbitrates die buttons, debounces press/release and
// turns hold time into a roll result with BCD display digits.
module dice_roll_controller
    import dice_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int ANIM_CYCLES     = 50000
) (
    input logic                    clk,
    input logic                    rst_n,
    dice_roll_controller_if.slave  bus
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int AW = $clog2(ANIM_CYCLES + 1);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [AW-1:0] ANIM_LAST = AW'(ANIM_CYCLES - 1);

    logic [6:0]    sync1_q, sync2_q, btn;
    state_t        state_q;
    logic [2:0]    sel_q;
    logic [DW-1:0] db_cnt_q;
    logic [AW-1:0] anim_cnt_q;
    logic [6:0]    roll_cnt_q, roll_nxt, shown;
    logic          has_result_q;
    logic [3:0]    digit1_q, digit10_q, tens, ones;
    logic [6:0]    result_q;
    logic          result_valid_q, rolling_q;
    logic          sel_pressed, show_now;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= bus.btn_raw;
            sync2_q <= sync1_q;
        end
    end

    assign btn         = sync2_q ^ {7{~bus.btn_active_high}};
    assign sel_pressed = btn[sel_q];
    assign roll_nxt    = roll_cnt_q == die_max(sel_q) ? 7'd0 : roll_cnt_q + 7'd1;
    assign shown       = roll_cnt_q + 7'd1;
    assign show_now    = state_q == RELEASE_DB && !sel_pressed && db_cnt_q == DB_LAST;

    dice_bin_to_bcd u_bcd (.val_i(shown), .tens_o(tens), .ones_o(ones));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            sel_q          <= '0;
            db_cnt_q       <= '0;
            anim_cnt_q     <= '0;
            roll_cnt_q     <= '0;
            has_result_q   <= 1'b0;
            digit1_q       <= BLANK;
            digit10_q      <= BLANK;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            rolling_q      <= 1'b0;
        end else if (!bus.ena) begin
            result_valid_q <= 1'b0;
        end else begin
            result_valid_q <= 1'b0;
            case (state_q)
                IDLE, SHOW: if (|btn) begin
                    state_q   <= PRESS_DB;
                    sel_q     <= lowest_set(btn);
                    db_cnt_q  <= '0;
                    rolling_q <= 1'b1;
                end
                PRESS_DB: if (!sel_pressed) begin
                    state_q   <= has_result_q ? SHOW : IDLE;
                    rolling_q <= 1'b0;
                end else if (db_cnt_q == DB_LAST) begin
                    state_q    <= ROLL;
                    roll_cnt_q <= '0;
                    anim_cnt_q <= '0;
                end else begin
                    db_cnt_q <= db_cnt_q + DW'(1);
                end
                ROLL: if (!sel_pressed) begin
                    state_q  <= RELEASE_DB;
                    db_cnt_q <= '0;
                end
                RELEASE_DB: if (show_now) begin
                    state_q        <= SHOW;
                    result_q       <= shown;
                    has_result_q   <= 1'b1;
                    result_valid_q <= 1'b1;
                    digit1_q       <= ones;
                    digit10_q      <= tens;
                    rolling_q      <= 1'b0;
                end else if (sel_pressed) begin
                    state_q  <= ROLL;
                    db_cnt_q <= '0;
                end else begin
                    db_cnt_q <= db_cnt_q + DW'(1);
                end
                default: state_q <= IDLE;
            endcase
            // The counter keeps running through release debounce; the SHOW edge captures it.
            if (state_q == ROLL || (state_q == RELEASE_DB && !show_now)) begin
                roll_cnt_q <= roll_nxt;
                anim_cnt_q <= anim_cnt_q == ANIM_LAST ? '0 : anim_cnt_q + AW'(1);
                if (anim_cnt_q == ANIM_LAST) begin
                    digit1_q  <= ones;
                    digit10_q <= tens;
                end
            end
        end
    end

    assign bus.digit1       = digit1_q;
    assign bus.digit10      = digit10_q;
    assign bus.result       = result_q;
    assign bus.result_valid = result_valid_q;
    assign bus.die_sel      = sel_q;
    assign bus.rolling      = rolling_q;
endmodule

// File: tb/tb_dice_roll_controller.sv
// tb_dice_roll_controller: scenario tasks plus randomized rolls checked against
// a hold-time arithmetic model of the dice roller.
module tb_dice_roll_controller;
    localparam int D = 4;
    localparam int A = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dice_roll_controller_if bus ();

    dice_roll_controller #(.DEBOUNCE_CYCLES(D), .ANIM_CYCLES(A)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    int checks = 0;
    int passes = 0;
    int rv_count = 0;

    always @(negedge clk) if (bus.result_valid === 1'b1) rv_count++;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic int die_n(input int idx);
        int t [7];
        t = '{4, 6, 8, 10, 12, 20, 100};
        return t[idx];
    endfunction

    // Holding the raw button for h edges yields h-1 counts: the press and release
    // latencies are equal and cancel, and the SHOW edge itself does not count.
    function automatic int roll_value(input int idx, input int h, input int frozen);
        return (h - 1 - frozen) % die_n(idx) + 1;
    endfunction

    function automatic logic [3:0] exp_tens(input int v);
        return v == 100 ? 4'd0 : v < 10 ? 4'hF : 4'(v / 10);
    endfunction

    function automatic logic [3:0] exp_ones(input int v);
        return v == 100 ? 4'd0 : 4'(v % 10);
    endfunction

    task automatic test_reset;
        bus.ena = 1'b1; bus.btn_active_high = 1'b1; bus.btn_raw = '0; rst_n = 1'b0;
        tick(3);
        checks++; if (bus.digit1 !== 4'hF || bus.digit10 !== 4'hF) $display("FAIL reset_digits_in_reset: got %h/%h expected f/f", bus.digit10, bus.digit1); else passes++;
        rst_n = 1'b1;
        rv_count = 0;
        tick(100);
        checks++; if (bus.digit1 !== 4'hF || bus.digit10 !== 4'hF) $display("FAIL reset_digits: got %h/%h expected f/f", bus.digit10, bus.digit1); else passes++;
        checks++; if (bus.result !== 7'd0) $display("FAIL reset_result: got %0d expected 0", bus.result); else passes++;
        checks++; if (bus.rolling !== 1'b0) $display("FAIL reset_rolling: got %b expected 0", bus.rolling); else passes++;
        checks++; if (bus.die_sel !== 3'd0) $display("FAIL reset_die_sel: got %0d expected 0", bus.die_sel); else passes++;
        checks++; if (rv_count !== 0) $display("FAIL reset_no_valid: got %0d pulses expected 0", rv_count); else passes++;
    endtask

    task automatic test_glitch;
        int rv0 = rv_count;
        bus.btn_raw = 7'h04; tick(2); bus.btn_raw = '0; tick(2);
        checks++; if (bus.rolling !== 1'b1) $display("FAIL glitch_press_db: rolling got %b expected 1", bus.rolling); else passes++;
        tick(10);
        checks++; if (bus.rolling !== 1'b0) $display("FAIL glitch_idle: rolling got %b expected 0", bus.rolling); else passes++;
        checks++; if (bus.digit1 !== 4'hF || bus.digit10 !== 4'hF) $display("FAIL glitch_digits: got %h/%h expected f/f", bus.digit10, bus.digit1); else passes++;
        checks++; if (rv_count !== rv0) $display("FAIL glitch_no_valid: got %0d pulses expected 0", rv_count - rv0); else passes++;
    endtask

    task automatic test_single_d6;
        int rv0 = rv_count;
        int v = roll_value(1, 14, 0);
        bus.btn_raw = 7'h02; tick(14); bus.btn_raw = '0; tick(D + 6);
        checks++; if (bus.result !== 7'(v) || v != 2) $display("FAIL d6_result: got %0d expected %0d", bus.result, v); else passes++;
        checks++; if (bus.digit10 !== 4'hF || bus.digit1 !== 4'd2) $display("FAIL d6_digits: got %h/%h expected f/2", bus.digit10, bus.digit1); else passes++;
        checks++; if (rv_count - rv0 !== 1) $display("FAIL d6_valid_pulses: got %0d expected 1", rv_count - rv0); else passes++;
        checks++; if (bus.die_sel !== 3'd1) $display("FAIL d6_die_sel: got %0d expected 1", bus.die_sel); else passes++;
        checks++; if (bus.rolling !== 1'b0) $display("FAIL d6_rolling: got %b expected 0", bus.rolling); else passes++;
    endtask

    task automatic test_simultaneous;
        int rv0 = rv_count;
        int v = roll_value(1, 30, 0);
        bus.btn_raw = 7'h22; tick(15);
        checks++; if (bus.die_sel !== 3'd1 || bus.rolling !== 1'b1) $display("FAIL simul_sel: die_sel %0d rolling %b expected 1/1", bus.die_sel, bus.rolling); else passes++;
        bus.btn_raw = 7'h02; tick(10);
        checks++; if (bus.digit10 !== 4'hF || bus.digit1 < 4'd1 || bus.digit1 > 4'd6) $display("FAIL simul_anim: got %h/%h expected f/1..6", bus.digit10, bus.digit1); else passes++;
        tick(5); bus.btn_raw = '0; tick(D + 6);
        checks++; if (bus.result !== 7'(v)) $display("FAIL simul_result: got %0d expected %0d", bus.result, v); else passes++;
        checks++; if (rv_count - rv0 !== 1) $display("FAIL simul_valid_pulses: got %0d expected 1", rv_count - rv0); else passes++;
        rv0 = rv_count;
        v = roll_value(6, 100, 0);
        bus.btn_raw = 7'h40; tick(100); bus.btn_raw = '0; tick(D + 6);
        checks++; if (bus.result !== 7'(v) || v != 100) $display("FAIL d100_result: got %0d expected %0d", bus.result, v); else passes++;
        checks++; if (bus.digit10 !== 4'd0 || bus.digit1 !== 4'd0) $display("FAIL d100_digits: got %h/%h expected 0/0", bus.digit10, bus.digit1); else passes++;
        checks++; if (bus.die_sel !== 3'd6 || rv_count - rv0 !== 1) $display("FAIL d100_sel_valid: die_sel %0d pulses %0d expected 6/1", bus.die_sel, rv_count - rv0); else passes++;
    endtask

    task automatic test_bounce;
        int rv0 = rv_count;
        int v = roll_value(2, 23, 0);
        bus.btn_raw = 7'h04; tick(20);
        bus.btn_raw = '0; tick(2);
        bus.btn_raw = 7'h04; tick(1);
        bus.btn_raw = '0; tick(D + 6);
        checks++; if (bus.result !== 7'(v)) $display("FAIL bounce_result: got %0d expected %0d", bus.result, v); else passes++;
        checks++; if (rv_count - rv0 !== 1) $display("FAIL bounce_valid_pulses: got %0d expected 1", rv_count - rv0); else passes++;
    endtask

    task automatic test_polarity;
        int rv0;
        int v = roll_value(3, 11, 0);
        bus.ena = 1'b0; bus.btn_active_high = 1'b0; bus.btn_raw = 7'h7F; tick(4);
        bus.ena = 1'b1; tick(4);
        checks++; if (bus.rolling !== 1'b0) $display("FAIL polarity_idle: rolling got %b expected 0", bus.rolling); else passes++;
        rv0 = rv_count;
        bus.btn_raw = 7'h77; tick(11); bus.btn_raw = 7'h7F; tick(D + 6);
        checks++; if (bus.result !== 7'(v) || v != 1) $display("FAIL polarity_result: got %0d expected %0d", bus.result, v); else passes++;
        checks++; if (bus.digit10 !== 4'hF || bus.digit1 !== 4'd1) $display("FAIL polarity_digits: got %h/%h expected f/1", bus.digit10, bus.digit1); else passes++;
        checks++; if (bus.die_sel !== 3'd3 || rv_count - rv0 !== 1) $display("FAIL polarity_sel_valid: die_sel %0d pulses %0d expected 3/1", bus.die_sel, rv_count - rv0); else passes++;
        bus.ena = 1'b0; bus.btn_active_high = 1'b1; bus.btn_raw = '0; tick(4);
        bus.ena = 1'b1; tick(2);
    endtask

    task automatic test_ena_freeze;
        int rv0 = rv_count;
        int v = roll_value(5, D + 5 + 20 + 30, 20);
        bus.btn_raw = 7'h20; tick(D + 5);
        bus.ena = 1'b0; tick(20);
        checks++; if (bus.rolling !== 1'b1 || rv_count !== rv0) $display("FAIL freeze_hold: rolling %b pulses %0d expected 1/0", bus.rolling, rv_count - rv0); else passes++;
        bus.ena = 1'b1; tick(30); bus.btn_raw = '0; tick(D + 6);
        checks++; if (bus.result !== 7'(v)) $display("FAIL freeze_result: got %0d expected %0d", bus.result, v); else passes++;
        checks++; if (bus.digit10 !== exp_tens(v) || bus.digit1 !== exp_ones(v)) $display("FAIL freeze_digits: got %h/%h expected %h/%h", bus.digit10, bus.digit1, exp_tens(v), exp_ones(v)); else passes++;
    endtask

    task automatic test_random;
        for (int k = 0; k < 6; k++) begin
            int idx = int'($urandom_range(0, 6));
            int h = int'($urandom_range(D + 1, 200));
            int v = roll_value(idx, h, 0);
            int rv0 = rv_count;
            bus.btn_raw = 7'(1 << idx); tick(h); bus.btn_raw = '0; tick(D + 6);
            checks++; if (bus.result !== 7'(v)) $display("FAIL rand_result[%0d]: die %0d hold %0d got %0d expected %0d", k, idx, h, bus.result, v); else passes++;
            checks++; if (bus.digit10 !== exp_tens(v) || bus.digit1 !== exp_ones(v)) $display("FAIL rand_digits[%0d]: got %h/%h expected %h/%h", k, bus.digit10, bus.digit1, exp_tens(v), exp_ones(v)); else passes++;
            checks++; if (bus.die_sel !== 3'(idx) || rv_count - rv0 !== 1) $display("FAIL rand_sel_valid[%0d]: die_sel %0d pulses %0d expected %0d/1", k, bus.die_sel, rv_count - rv0, idx); else passes++;
        end
    endtask

    task automatic test_reset_mid_roll;
        int rv0;
        bus.btn_raw = 7'h10; tick(D + 12);
        checks++; if (bus.rolling !== 1'b1) $display("FAIL midreset_rolling_before: got %b expected 1", bus.rolling); else passes++;
        rst_n = 1'b0; #1;
        checks++; if (bus.digit1 !== 4'hF || bus.digit10 !== 4'hF || bus.rolling !== 1'b0 || bus.result !== 7'd0) $display("FAIL midreset_immediate: digits %h/%h rolling %b result %0d expected f/f 0 0", bus.digit10, bus.digit1, bus.rolling, bus.result); else passes++;
        bus.btn_raw = '0; tick(2); rst_n = 1'b1;
        rv0 = rv_count;
        tick(D + 8);
        checks++; if (bus.digit1 !== 4'hF || bus.digit10 !== 4'hF || bus.rolling !== 1'b0) $display("FAIL midreset_idle: digits %h/%h rolling %b expected f/f 0", bus.digit10, bus.digit1, bus.rolling); else passes++;
        checks++; if (rv_count !== rv0) $display("FAIL midreset_no_valid: got %0d pulses expected 0", rv_count - rv0); else passes++;
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_single_d6();
        test_simultaneous();
        test_bounce();
        test_polarity();
        test_ena_freeze();
        test_random();
        test_reset_mid_roll();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
